// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter and setup/access/done sequencer for the shared memory bus.
// Define ARB_LOCK_EN to let a master hold the bus across transfers via lock[].
module mem_bus_arbiter #(
  parameter int unsigned ADDR_W      = 13,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_ack,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_ack,
  input  logic [1:0]        lock,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic              mem_oe,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

  state_t            state, state_n;
  logic              sel, sel_n, we_q, we_n, last_grant, last_n;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic [DATA_W-1:0] wdata_q, wdata_n, rdata_q, rdata_n;
  logic [3:0]        cnt, cnt_n;
  logic [1:0]        gnt_q, gnt_n, ack_q, ack_n;
  logic              rd_q, rd_n, wr_q, wr_n, oe_q, oe_n, busy_q, busy_n;
  logic [1:0]        req;
  logic              pick_valid, pick;

`ifdef ARB_LOCK_EN
  logic lock_held, lock_n;
`else
  logic [1:0] lock_unused;
  assign lock_unused = lock;
`endif

  assign req = {m1_req, m0_req};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      sel        <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      cnt        <= '0;
      last_grant <= 1'b1;
      gnt_q      <= '0;
      ack_q      <= '0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      oe_q       <= 1'b0;
      busy_q     <= 1'b0;
`ifdef ARB_LOCK_EN
      lock_held  <= 1'b0;
`endif
    end else begin
      state      <= state_n;
      sel        <= sel_n;
      we_q       <= we_n;
      addr_q     <= addr_n;
      wdata_q    <= wdata_n;
      rdata_q    <= rdata_n;
      cnt        <= cnt_n;
      last_grant <= last_n;
      gnt_q      <= gnt_n;
      ack_q      <= ack_n;
      rd_q       <= rd_n;
      wr_q       <= wr_n;
      oe_q       <= oe_n;
      busy_q     <= busy_n;
`ifdef ARB_LOCK_EN
      lock_held  <= lock_n;
`endif
    end
  end

  always_comb begin
    state_n    = state;
    sel_n      = sel;
    we_n       = we_q;
    addr_n     = addr_q;
    wdata_n    = wdata_q;
    rdata_n    = rdata_q;
    cnt_n      = cnt;
    last_n     = last_grant;
    pick_valid = |req;
    pick       = (&req) ? ~last_grant : req[1];
`ifdef ARB_LOCK_EN
    lock_n = lock_held;
    // A locked owner that stops requesting releases the bus so the other master cannot starve.
    if (state == IDLE && lock_held) begin
      if (req[last_grant]) pick = last_grant;
      else                 lock_n = 1'b0;
    end
`endif
    case (state)
      IDLE: begin
        if (pick_valid) begin
          state_n = SETUP;
          sel_n   = pick;
          we_n    = pick ? m1_we    : m0_we;
          addr_n  = pick ? m1_addr  : m0_addr;
          wdata_n = pick ? m1_wdata : m0_wdata;
          cnt_n   = 4'(WAIT_STATES);
        end
      end
      SETUP: state_n = ACCESS;
      ACCESS: begin
        if (cnt == '0) begin
          state_n = DONE;
          if (!we_q) rdata_n = mem_rdata;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      DONE: begin
        state_n = IDLE;
        last_n  = sel;
`ifdef ARB_LOCK_EN
        lock_n  = lock[sel];
`endif
      end
      default: state_n = IDLE;
    endcase

    // Outputs are decoded from the next state so every output comes straight from a flop.
    gnt_n  = (state_n != IDLE) ? (sel_n ? 2'b10 : 2'b01) : 2'b00;
    ack_n  = (state_n == DONE) ? (sel_n ? 2'b10 : 2'b01) : 2'b00;
    rd_n   = (state_n == ACCESS) && !we_n;
    wr_n   = (state_n == ACCESS) && we_n;
    oe_n   = wr_n;
    busy_n = (state_n != IDLE);
  end

  assign m0_gnt    = gnt_q[0];
  assign m1_gnt    = gnt_q[1];
  assign m0_ack    = ack_q[0];
  assign m1_ack    = ack_q[1];
  assign rdata     = rdata_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_rd    = rd_q;
  assign mem_wr    = wr_q;
  assign mem_oe    = oe_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: transfer-timeline reference model plus a simple memory.
module tb_mem_bus_arbiter;
  localparam int unsigned AW = 13;
  localparam int unsigned DW = 8;
  localparam int          WS = 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          m0_req, m0_we, m1_req, m1_we;
  logic [AW-1:0] m0_addr, m1_addr, mem_addr;
  logic [DW-1:0] m0_wdata, m1_wdata, rdata, mem_wdata, mem_rdata;
  logic          m0_gnt, m0_ack, m1_gnt, m1_ack, mem_rd, mem_wr, mem_oe, busy;
  logic [1:0]    lock;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_STATES(WS)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_ack(m0_ack),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_ack(m1_ack),
    .lock(lock), .rdata(rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_oe(mem_oe), .busy(busy)
  );

  function automatic logic [7:0] pattern(logic [12:0] a);
    if (a == 13'h0005) return 8'hA5;
    return (a[7:0] * 8'd37) ^ {3'b000, a[12:8]};
  endfunction

  // Memory: unwritten locations read back a fixed pattern; bus idle value is EE.
  logic [7:0] wmem   [0:8191];
  bit         wvalid [0:8191];
  always @(posedge clk) begin
    if (mem_wr) begin
      wmem[mem_addr]   <= mem_wdata;
      wvalid[mem_addr] <= 1'b1;
    end
  end
  always @* begin
    if (!mem_rd)               mem_rdata = 8'hEE;
    else if (wvalid[mem_addr]) mem_rdata = wmem[mem_addr];
    else                       mem_rdata = pattern(mem_addr);
  end

  int checks = 0;
  int errors = 0;

  // Reference model: a transfer started at edge st shows SETUP at d=0, ACCESS at
  // d=1..1+WS, DONE at d=2+WS, one IDLE cycle, and the next arbitration at d=4+WS.
  int          edge_n;
  bit          act, msel, mwe, mlast, mlocked, keep0, keep1;
  int          st;
  logic [12:0] maddr;
  logic [7:0]  mwdata, exp_rdata, ectl;
  logic [7:0]  ref_val [0:8191];
  bit          ref_ok  [0:8191];

  function automatic logic [7:0] exp_ctl();
    logic [7:0] v;
    int d;
    v = '0;
    d = edge_n - st;
    if (!act || d > 2 + WS) return v;
    v[7] = 1'b1;
    if (msel) v[5] = 1'b1; else v[6] = 1'b1;
    if (d == 2 + WS) begin
      if (msel) v[3] = 1'b1; else v[4] = 1'b1;
    end
    if (d >= 1 && d <= 1 + WS) begin
      v[2] = !mwe;
      v[1] = mwe;
      v[0] = mwe;
    end
    return v;
  endfunction

  function automatic logic [7:0] obs_ctl();
    return {busy, m0_gnt, m1_gnt, m0_ack, m1_ack, mem_rd, mem_wr, mem_oe};
  endfunction

  task automatic model_reset();
    act = 1'b0; mlast = 1'b1; mlocked = 1'b0; exp_rdata = '0;
  endtask

  task automatic model_edge();
    logic [1:0] r;
    bit p;
    int d;
    r = {m1_req, m0_req};
    if (act) begin
      d = edge_n - st;
      if (d == 2 + WS) begin
        if (mwe) begin ref_val[maddr] = mwdata; ref_ok[maddr] = 1'b1; end
        else exp_rdata = ref_ok[maddr] ? ref_val[maddr] : pattern(maddr);
      end
      if (d == 3 + WS) begin
        mlast = msel;
`ifdef ARB_LOCK_EN
        mlocked = lock[msel];
`endif
      end
      if (d >= 4 + WS) act = 1'b0;
    end
    if (!act) begin
      if (mlocked && !r[mlast]) mlocked = 1'b0;
      if (r != 2'b00) begin
        p = (r == 2'b11) ? !mlast : r[1];
        if (mlocked) p = mlast;
        act = 1'b1; st = edge_n; msel = p;
        mwe    = p ? m1_we    : m0_we;
        maddr  = p ? m1_addr  : m0_addr;
        mwdata = p ? m1_wdata : m0_wdata;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    edge_n++;
    model_edge();
    #1;
    ectl = exp_ctl();
    if (ectl[4] && !keep0) m0_req = 1'b0;
    if (ectl[3] && !keep1) m1_req = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    m0_req = 1'b0; m1_req = 1'b0; lock = 2'b00; keep0 = 1'b0; keep1 = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic issue0(input bit we, input logic [12:0] a, input logic [7:0] d);
    m0_req = 1'b1; m0_we = we; m0_addr = a; m0_wdata = d;
  endtask

  task automatic issue1(input bit we, input logic [12:0] a, input logic [7:0] d);
    m1_req = 1'b1; m1_we = we; m1_addr = a; m1_wdata = d;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    m0_req = 1'b0; m1_req = 1'b0; m0_we = 1'b0; m1_we = 1'b0; lock = 2'b00;
    m0_addr = '0; m1_addr = '0; m0_wdata = '0; m1_wdata = '0;
    #1;
    checks++;
    if (obs_ctl() !== 8'h00 || rdata !== 8'h00 || mem_addr !== 13'h0 || mem_wdata !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs: got ctl=%b rdata=%h addr=%h wdata=%h, want all zero",
               obs_ctl(), rdata, mem_addr, mem_wdata);
    end
    do_reset();
    step();
    checks++;
    if (obs_ctl() !== 8'h00) begin
      errors++; $display("FAIL idle_after_reset: got ctl=%b want 00000000", obs_ctl());
    end
  endtask

  task automatic test_single_read();
    int rd_cnt = 0, ack_at = -1;
    bit m1_seen = 1'b0;
    issue0(1'b0, 13'h0005, 8'h00);
    for (int i = 1; i <= 8; i++) begin
      step();
      checks++;
      if (obs_ctl() !== ectl || rdata !== exp_rdata) begin
        errors++;
        $display("FAIL read_ctl cyc %0d: got ctl=%b rdata=%h want ctl=%b rdata=%h",
                 i, obs_ctl(), rdata, ectl, exp_rdata);
      end
      if (mem_rd) rd_cnt++;
      if (m1_gnt) m1_seen = 1'b1;
      if (m0_ack && ack_at < 0) ack_at = i;
    end
    checks++;
    if (rd_cnt !== WS + 1) begin errors++; $display("FAIL read_strobe_len: got %0d want %0d", rd_cnt, WS + 1); end
    checks++;
    if (ack_at !== 3 + WS) begin errors++; $display("FAIL read_ack_latency: got %0d want %0d", ack_at, 3 + WS); end
    checks++;
    if (rdata !== 8'hA5) begin errors++; $display("FAIL read_data: got %h want a5", rdata); end
    checks++;
    if (m1_seen) begin errors++; $display("FAIL read_m1_gnt: got 1 want 0"); end
  endtask

  task automatic test_write();
    int wr_cnt = 0, ack_cnt = 0;
    issue1(1'b1, 13'h1FFF, 8'h3C);
    for (int i = 1; i <= 8; i++) begin
      step();
      checks++;
      if (obs_ctl() !== ectl || rdata !== exp_rdata) begin
        errors++;
        $display("FAIL write_ctl cyc %0d: got ctl=%b rdata=%h want ctl=%b rdata=%h",
                 i, obs_ctl(), rdata, ectl, exp_rdata);
      end
      if (mem_wr) begin
        wr_cnt++;
        checks++;
        if (mem_wdata !== 8'h3C || mem_oe !== 1'b1 || mem_addr !== 13'h1FFF) begin
          errors++;
          $display("FAIL write_bus: got wdata=%h oe=%b addr=%h want 3c 1 1fff", mem_wdata, mem_oe, mem_addr);
        end
      end
      if (m1_ack) ack_cnt++;
    end
    checks++;
    if (wr_cnt !== WS + 1) begin errors++; $display("FAIL write_strobe_len: got %0d want %0d", wr_cnt, WS + 1); end
    checks++;
    if (ack_cnt !== 1) begin errors++; $display("FAIL write_ack_count: got %0d want 1", ack_cnt); end
    checks++;
    if (rdata !== 8'hA5) begin errors++; $display("FAIL write_rdata_kept: got %h want a5", rdata); end
    issue0(1'b0, 13'h1FFF, 8'h00);
    for (int i = 1; i <= 8; i++) begin
      step();
      checks++;
      if (obs_ctl() !== ectl || rdata !== exp_rdata) begin
        errors++;
        $display("FAIL readback_ctl cyc %0d: got ctl=%b rdata=%h want ctl=%b rdata=%h",
                 i, obs_ctl(), rdata, ectl, exp_rdata);
      end
    end
    checks++;
    if (rdata !== 8'h3C) begin errors++; $display("FAIL readback_data: got %h want 3c", rdata); end
  endtask

  task automatic test_contention();
    int q[$];
    keep0 = 1'b1; keep1 = 1'b1;
    issue0(1'b0, 13'h0003, 8'h00);
    issue1(1'b1, 13'h0004, 8'h77);
    for (int i = 1; i <= 4 * (4 + WS) + 2; i++) begin
      step();
      checks++;
      if (obs_ctl() !== ectl || rdata !== exp_rdata) begin
        errors++;
        $display("FAIL contend_ctl cyc %0d: got ctl=%b rdata=%h want ctl=%b rdata=%h",
                 i, obs_ctl(), rdata, ectl, exp_rdata);
      end
      checks++;
      if ((m0_gnt && m1_gnt) || (mem_rd && mem_wr)) begin
        errors++;
        $display("FAIL contend_exclusive: got gnt=%b%b rd/wr=%b%b want no overlap", m1_gnt, m0_gnt, mem_rd, mem_wr);
      end
      if (m0_ack) q.push_back(0);
      if (m1_ack) q.push_back(1);
    end
    checks++;
    if (q.size() < 4) begin errors++; $display("FAIL contend_count: got %0d want >=4", q.size()); end
    for (int i = 1; i < q.size(); i++) begin
      checks++;
      if (q[i] == q[i-1]) begin errors++; $display("FAIL contend_alternate at %0d: got %0d twice want alternation", i, q[i]); end
    end
    keep0 = 1'b0; keep1 = 1'b0; m0_req = 1'b0; m1_req = 1'b0;
    for (int i = 1; i <= 2 * (4 + WS); i++) begin
      step();
      checks++;
      if (obs_ctl() !== ectl) begin
        errors++; $display("FAIL contend_drain cyc %0d: got ctl=%b want ctl=%b", i, obs_ctl(), ectl);
      end
    end
  endtask

  task automatic test_async_reset();
    int ack_bad = 0, ack_cnt = 0;
    issue0(1'b0, 13'h0009, 8'h00);
    repeat (2) step();
    checks++;
    if (mem_rd !== 1'b1 || m0_gnt !== 1'b1) begin
      errors++; $display("FAIL areset_pre: got rd=%b gnt=%b want 1 1", mem_rd, m0_gnt);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (obs_ctl() !== 8'h00) begin
      errors++; $display("FAIL areset_drop: got ctl=%b want 00000000", obs_ctl());
    end
    model_reset();
    m0_req = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      if (m0_ack) ack_bad++;
    end
    checks++;
    if (ack_bad !== 0) begin errors++; $display("FAIL areset_no_ack: got %0d acks want 0", ack_bad); end
    @(negedge clk);
    reset = 1'b1;
    issue0(1'b0, 13'h0009, 8'h00);
    for (int i = 1; i <= 8; i++) begin
      step();
      checks++;
      if (obs_ctl() !== ectl || rdata !== exp_rdata) begin
        errors++;
        $display("FAIL areset_after cyc %0d: got ctl=%b rdata=%h want ctl=%b rdata=%h",
                 i, obs_ctl(), rdata, ectl, exp_rdata);
      end
      if (m0_ack) ack_cnt++;
    end
    checks++;
    if (ack_cnt !== 1) begin errors++; $display("FAIL areset_fresh_ack: got %0d want 1", ack_cnt); end
  endtask

  task automatic test_req_drop();
    int ack_cnt = 0;
    issue0(1'b0, 13'h0007, 8'h00);
    step();
    m0_req = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      step();
      checks++;
      if (obs_ctl() !== ectl || rdata !== exp_rdata) begin
        errors++;
        $display("FAIL drop_ctl cyc %0d: got ctl=%b rdata=%h want ctl=%b rdata=%h",
                 i, obs_ctl(), rdata, ectl, exp_rdata);
      end
      if (m0_ack) ack_cnt++;
    end
    checks++;
    if (ack_cnt !== 1 || busy !== 1'b0) begin
      errors++; $display("FAIL drop_complete: got acks=%0d busy=%b want 1 0", ack_cnt, busy);
    end
  endtask

  function automatic logic [12:0] rand_addr();
    return ($urandom_range(0, 7) == 0) ? 13'h1FFF : 13'($urandom_range(0, 15));
  endfunction

  task automatic test_random();
    int d;
    for (int i = 0; i < 400; i++) begin
      if (!m0_req && $urandom_range(0, 2) == 0) issue0(1'($urandom), rand_addr(), 8'($urandom));
      if (!m1_req && $urandom_range(0, 2) == 0) issue1(1'($urandom), rand_addr(), 8'($urandom));
      step();
      d = edge_n - st;
      checks++;
      if (obs_ctl() !== ectl || rdata !== exp_rdata) begin
        errors++;
        $display("FAIL rand_ctl cyc %0d: got ctl=%b rdata=%h want ctl=%b rdata=%h",
                 i, obs_ctl(), rdata, ectl, exp_rdata);
      end
      if (act && d <= 2 + WS) begin
        checks++;
        if (mem_addr !== maddr || (mwe && mem_wdata !== mwdata)) begin
          errors++;
          $display("FAIL rand_bus cyc %0d: got addr=%h wdata=%h want addr=%h wdata=%h",
                   i, mem_addr, mem_wdata, maddr, mwdata);
        end
      end
      if (ectl[4] && m0_req) issue0(1'($urandom), rand_addr(), 8'($urandom));
      if (ectl[3] && m1_req) issue1(1'($urandom), rand_addr(), 8'($urandom));
      if (ectl[4]) keep0 = 1'($urandom);
      if (ectl[3]) keep1 = 1'($urandom);
    end
    keep0 = 1'b0; keep1 = 1'b0; m0_req = 1'b0; m1_req = 1'b0;
    repeat (2 * (4 + WS)) step();
  endtask

`ifdef ARB_LOCK_EN
  task automatic test_lock();
    int q[$];
    do_reset();
    issue0(1'b0, 13'h0002, 8'h00);
    repeat (6) step();
    keep0 = 1'b1; keep1 = 1'b1; lock = 2'b10;
    issue0(1'b0, 13'h0004, 8'h00);
    issue1(1'b0, 13'h0006, 8'h00);
    for (int i = 1; i <= 3 * (4 + WS) + 2; i++) begin
      step();
      checks++;
      if (obs_ctl() !== ectl) begin
        errors++; $display("FAIL lock_ctl cyc %0d: got ctl=%b want ctl=%b", i, obs_ctl(), ectl);
      end
      if (m0_ack) q.push_back(0);
      if (m1_ack) q.push_back(1);
      if (q.size() == 1 && !m1_ack) lock = 2'b00;
    end
    checks++;
    if (q.size() < 3 || q[0] != 1 || q[1] != 1 || q[2] != 0) begin
      errors++; $display("FAIL lock_order: got %p want 1,1,0", q);
    end
    keep0 = 1'b0; keep1 = 1'b0; m0_req = 1'b0; m1_req = 1'b0;
    repeat (2 * (4 + WS)) step();
  endtask
`endif

  initial begin
    edge_n = 0; st = 0;
    test_reset();
    test_single_read();
    test_write();
    test_contention();
    test_async_reset();
    test_req_drop();
    test_random();
`ifdef ARB_LOCK_EN
    test_lock();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Two-master arbiter and sequencer for the shared 13-bit address / 8-bit data memory bus of the RISC CPU.
- Master 0 is the CPU core; master 1 is a DMA/program loader.
- Grants one master at a time with round-robin fairness and runs a fixed setup/access/ack sequence with programmable wait states.
- Drives the single memory-side rd/wr strobe pair; the top level owns the tristate using mem_oe.

Parameters:
ADDR_W, 13, address width of masters and memory bus
DATA_W, 8, data width
WAIT_STATES, 1, extra ACCESS cycles per transfer, legal range 0..15

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous active-low reset
m0_req  input  1  master 0 transfer request, level
m0_we  input  1  master 0 direction, 1=write 0=read
m0_addr  input  ADDR_W  master 0 address
m0_wdata  input  DATA_W  master 0 write data
m0_gnt  output  1  master 0 owns bus, SETUP through DONE
m0_ack  output  1  master 0 transfer complete, 1-cycle pulse
m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_ack  as master 0, for master 1
lock  input  2  per-master bus lock request, see Optional Feature
rdata  output  DATA_W  read data of last completed read, shared by both masters
mem_addr  output  ADDR_W  memory address
mem_wdata  output  DATA_W  memory write data
mem_rdata  input  DATA_W  memory read data
mem_rd  output  1  memory read strobe
mem_wr  output  1  memory write strobe
mem_oe  output  1  write-data output enable for top-level tristate
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE; all outputs go to 0; internal address/data registers clear.
  - last_grant resets to 1, so master 0 wins the first tie.
- States: IDLE -> SETUP -> ACCESS -> DONE -> IDLE. All outputs are registered.
- IDLE:
  - Only m0_req -> select 0; only m1_req -> select 1.
  - Both requesting -> select the master that is not last_grant.
  - Neither requesting -> stay in IDLE.
  - On select: latch that master's we/addr/wdata; load the wait counter with WAIT_STATES; next state SETUP.
- SETUP (1 cycle): mem_addr valid; selected gnt=1; mem_rd=mem_wr=0.
- ACCESS (WAIT_STATES+1 cycles): mem_rd=~we or mem_wr=we; mem_oe=we; mem_addr and mem_wdata held stable.
  - The counter decrements each cycle; exit to DONE when the counter is 0.
  - Reads: capture mem_rdata into rdata on the final ACCESS cycle.
- DONE (1 cycle): strobes low; selected ack=1; gnt stays 1; last_grant updates to the selected master; next state IDLE.
- Latency: req sampled in IDLE at edge N gives ack high in cycle N+3+WAIT_STATES. Minimum transfer-to-transfer spacing is 4+WAIT_STATES cycles.
- rdata holds its value until the next completed read; writes do not disturb it.
- A master must hold req/we/addr/wdata until ack. Dropping req mid-transfer is ignored and the transfer completes with ack. Req still high after ack is a new request.
- Never: both gnt high; ack without a prior gnt; mem_rd and mem_wr high together.
- Asynchronous reset mid-transfer aborts immediately: strobes drop the same instant and no ack is issued.

Optional Feature:
- Macro ARB_LOCK_EN.
- Defined:
  - If lock[sel] is high during DONE, the master keeps ownership: IDLE considers only that master's req.
  - Lock releases when the owner completes a transfer with lock[sel] low, or when its req is low in IDLE (deadlock guard).
  - Round-robin resumes after release. Typical use is atomic read-modify-write.
- Not defined: the lock port is ignored and pure round-robin applies.

Test Plan:
- After reset, only m0_req, read addr 13'h0005 with mem_rdata=8'hA5, WAIT_STATES=1 -> mem_rd high 2 cycles, m0_ack at cycle 4 after req, rdata=8'hA5, m1_gnt never high.
- m1 write addr 13'h1FFF data 8'h3C -> mem_wr and mem_oe high WAIT_STATES+1 cycles with mem_wdata=8'h3C, then m1_ack for 1 cycle, rdata unchanged.
- m0_req and m1_req held high continuously -> grants alternate 0,1,0,1; no gnt overlap; mem_rd&mem_wr never both high.
- reset pulled low during ACCESS of an m0 read -> strobes, gnt and busy drop immediately; no m0_ack; after release, a fresh m0 request completes normally.
- m0_req dropped during SETUP -> transfer still completes, one m0_ack, then IDLE.
- ARB_LOCK_EN defined, lock[1]=1 with m1 and m0 requesting -> m1 served twice consecutively; lock[1]=0 on the second transfer -> m0 granted next.
